vx_scoreboard: RTL
==================

Name: VX_scoreboard

Overview:
- Per-warp register-pending tracker; the producer-side counterpart to the decode-stage forwarding check.
- Issue marks a destination register pending. Writeback clears it.
- Decode consults the table and stalls on RAW/WAW hazards against in-flight writes.
- Sits between decode/issue and writeback; one bit per (warp, register).

Parameters:
- NW, 8, number of warps (warp index width = $clog2(NW)).
- NR, 32, architectural registers per warp; register 0 never tracked.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_issue_valid  in  1  decode presents an instruction.
- in_issue_warp_num  in  $clog2(NW)  warp of issuing instruction.
- in_issue_src1  in  5  source register 1.
- in_issue_src2  in  5  source register 2.
- in_issue_rd  in  5  destination register.
- in_issue_wb  in  2  writeback kind (`NO_WB, `WB_ALU, `WB_MEM, `WB_JAL).
- in_writeback_valid  in  1  writeback stage retiring a write.
- in_writeback_warp_num  in  $clog2(NW)  retiring warp.
- in_writeback_dest  in  5  retiring destination.
- in_flush_valid  in  1  squash all pending state of one warp.
- in_flush_warp_num  in  $clog2(NW)  warp to flush.
- out_issue_stall  out  1  hazard: decode must hold.
- out_issue_fire  out  1  issue accepted this cycle (valid & !stall).
- out_warp_busy  out  NW  bit w = warp w has any pending register.
- out_pending_count  out  $clog2(NW*NR)+1  total pending bits, registered.

Behaviour:
- State: pending[NW][NR] flops. On reset low, all bits clear, out_pending_count=0, out_warp_busy=0, and out_issue_stall=0 immediately (asynchronously).
- Hazard check (combinational from registered state):
  - hit(r) = r!=0 & pending[in_issue_warp_num][r].
  - out_issue_stall = in_issue_valid & (hit(src1) | hit(src2) | (in_issue_wb!=`NO_WB & hit(rd))).
  - With in_issue_valid=0, stall=0.
- Set: when out_issue_fire & in_issue_wb!=`NO_WB & rd!=0, pending[warp][rd] is 1 on the next edge.
- Clear: when in_writeback_valid & dest!=0, pending[wb_warp][dest] is 0 on the next edge. Clearing a bit already 0 is legal and has no effect.
- Same-cycle set and clear of the same (warp, reg): set wins (the younger write is outstanding). WAW stall makes this reachable only via the bypass below.
- Flush: all bits of in_flush_warp_num go to 0 on the next edge. Flush overrides set and clear for that warp. Issue to the flushed warp in that cycle still reports fire but sets nothing.
- out_warp_busy[w] = OR of pending[w][*], combinational from state.
- out_pending_count: updated each edge to the popcount of the next state, so it equals popcount(pending) with 1-cycle latency. Never wraps: max NW*(NR-1) fits the width.
- Latency: a set is visible to hazard checks the cycle after issue. A clear is visible the cycle after writeback, unless the bypass is enabled.

Optional Feature:
- Macro SCB_WB_BYPASS_EN.
- When defined: a same-cycle writeback matching (warp, reg) masks that register's hit in the stall equation, so a dependent instruction issues in the writeback cycle. A set and clear then coinciding on the same bit resolves to set.
- When undefined: hit uses registered state only, and a dependent instruction stalls through the writeback cycle and issues one cycle later.

Decomposition:
- Shared package/define file: WB kind encodings (`NO_WB, `WB_ALU, `WB_MEM, `WB_JAL), `ZERO_REG, STALL/NO_STALL constants, warp index width.
- One natural sub-module: VX_scoreboard_warp (NR-bit pending vector with set/clear/flush ports, read taps for 3 registers, busy output), instantiated NW times via generate.
- Popcount and stall OR-reduction stay in the top.

Test Plan:
- Reset: hold reset=0 with issue valid, src1=5 → stall=0, busy=0, count=0. Release, issue w0 rd=5 ALU → next cycle count=1, busy[0]=1.
- RAW: w0 rd=5 issued, then w0 src1=5 → stall=1 each cycle until writeback w0 dest=5. Without bypass, issue fires the cycle after writeback. With SCB_WB_BYPASS_EN, it fires in the writeback cycle.
- Warp isolation and x0: w0 rd=5 pending, w1 src1=5 → no stall. Issue rd=0 → count unchanged. Src=0 never stalls.
- WAW: w2 rd=7 pending, w2 issues rd=7 `WB_MEM with unrelated sources → stall=1. Same with wb=`NO_WB → no stall and no set.
- Flush: w3 rd=1,2,9 pending (count=3). Flush w3 in the same cycle as writeback w3 dest=1 and issue w3 rd=4 → next cycle busy[3]=0, count=0, fire was 1.
- Fill: set every reg 1..31 in all 8 warps → count=248. Retire all → 0, no wrap.

Source files
------------

// File: rtl/vx_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// vx_scoreboard_pkg
//
// Shared definitions for the register scoreboard.
//   - wb_kind_e : writeback kind of an issuing instruction
//                 (NO_WB, WB_ALU, WB_MEM, WB_JAL)
//   - ZERO_REG  : architectural x0, never tracked
//   - STALL / NO_STALL : values of the issue stall output
//   - NUM_WARPS / NUM_REGS / WARP_W / REG_W : default geometry
// ---------------------------------------------------------------------------
package vx_scoreboard_pkg;

  localparam int NUM_WARPS = 8;
  localparam int NUM_REGS  = 32;
  localparam int WARP_W    = $clog2(NUM_WARPS);
  localparam int REG_W     = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    NO_WB  = 2'd0,
    WB_ALU = 2'd1,
    WB_MEM = 2'd2,
    WB_JAL = 2'd3
  } wb_kind_e;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  localparam logic STALL    = 1'b1;
  localparam logic NO_STALL = 1'b0;

endpackage

// File: rtl/vx_scoreboard_warp.sv
// ---------------------------------------------------------------------------
// vx_scoreboard_warp
//
// Pending-register vector for a single warp.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   set_valid, set_reg  : mark set_reg pending on the next edge
//   clr_valid, clr_reg  : clear clr_reg on the next edge
//   flush               : clear every bit on the next edge
//   tap_src1/src2/rd    : three read taps (register numbers)
//   tap_hit1/hit2/hitd  : tap register is pending (x0 never hits)
//   busy                : any register of this warp is pending
//   pending_next        : next-state vector, used for the shared popcount
// ---------------------------------------------------------------------------
module vx_scoreboard_warp
  import vx_scoreboard_pkg::*;
#(
  parameter int NR = NUM_REGS,
  parameter int RW = $clog2(NR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_valid,
  input  logic [RW-1:0] set_reg,
  input  logic          clr_valid,
  input  logic [RW-1:0] clr_reg,
  input  logic          flush,
  input  logic [RW-1:0] tap_src1,
  input  logic [RW-1:0] tap_src2,
  input  logic [RW-1:0] tap_rd,
  output logic          tap_hit1,
  output logic          tap_hit2,
  output logic          tap_hitd,
  output logic          busy,
  output logic [NR-1:0] pending_next
);

  logic [NR-1:0] pending_q;

  // Next-state ordering matters: the clear is applied first so that a
  // coinciding set on the same bit survives (the younger write is still
  // outstanding), and flush is applied last so it overrides both.
  always_comb begin
    pending_next = pending_q;
    if (clr_valid && (clr_reg != '0)) begin
      pending_next[clr_reg] = 1'b0;
    end
    if (set_valid && (set_reg != '0)) begin
      pending_next[set_reg] = 1'b1;
    end
    if (flush) begin
      pending_next = '0;
    end
  end

  // State register; reset clears all pending bits immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_next;
    end
  end

  // Read taps look only at registered state; x0 is excluded explicitly
  // so the table never has to keep bit 0 clear by construction.
  always_comb begin
    tap_hit1 = (tap_src1 != '0) && pending_q[tap_src1];
    tap_hit2 = (tap_src2 != '0) && pending_q[tap_src2];
    tap_hitd = (tap_rd   != '0) && pending_q[tap_rd];
    busy     = |pending_q;
  end

endmodule

// File: rtl/vx_scoreboard.sv
// ---------------------------------------------------------------------------
// vx_scoreboard
//
// Per-warp register-pending tracker. Issue marks a destination pending,
// writeback clears it, and decode is stalled on RAW/WAW hazards against
// writes still in flight. Flush squashes all pending state of one warp.
//
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   in_issue_valid             : decode presents an instruction
//   in_issue_warp_num          : warp of the issuing instruction
//   in_issue_src1/src2/rd      : source and destination registers
//   in_issue_wb                : writeback kind (wb_kind_e)
//   in_writeback_valid/warp_num/dest : retiring write
//   in_flush_valid/warp_num    : squash all pending bits of one warp
//   out_issue_stall            : hazard, decode must hold
//   out_issue_fire             : issue accepted this cycle
//   out_warp_busy              : bit w = warp w has a pending register
//   out_pending_count          : total pending bits (registered)
//
// Optional feature: define SCB_WB_BYPASS_EN to let a same-cycle writeback
// mask the matching hazard, so a dependent instruction issues in the
// writeback cycle instead of the cycle after.
// ---------------------------------------------------------------------------
module vx_scoreboard
  import vx_scoreboard_pkg::*;
#(
  parameter  int NW = NUM_WARPS,
  parameter  int NR = NUM_REGS,
  localparam int WW = $clog2(NW),
  localparam int RW = $clog2(NR),
  localparam int CW = $clog2(NW*NR) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_issue_valid,
  input  logic [WW-1:0] in_issue_warp_num,
  input  logic [RW-1:0] in_issue_src1,
  input  logic [RW-1:0] in_issue_src2,
  input  logic [RW-1:0] in_issue_rd,
  input  logic [1:0]    in_issue_wb,
  input  logic          in_writeback_valid,
  input  logic [WW-1:0] in_writeback_warp_num,
  input  logic [RW-1:0] in_writeback_dest,
  input  logic          in_flush_valid,
  input  logic [WW-1:0] in_flush_warp_num,
  output logic          out_issue_stall,
  output logic          out_issue_fire,
  output logic [NW-1:0] out_warp_busy,
  output logic [CW-1:0] out_pending_count
);

  logic [NW-1:0]         hit1_w;
  logic [NW-1:0]         hit2_w;
  logic [NW-1:0]         hitd_w;
  logic [NW-1:0][NR-1:0] next_w;
  logic                  issue_writes;
  logic                  hit1;
  logic                  hit2;
  logic                  hitd;
  logic [CW-1:0]         count_next;

  assign issue_writes = (in_issue_wb != NO_WB);

  // One pending vector per warp. Every warp taps the same issue registers;
  // the issuing warp's taps are selected below.
  for (genvar w = 0; w < NW; w++) begin : g_warp
    logic set_valid;
    logic clr_valid;
    logic flush;

    assign set_valid = out_issue_fire && issue_writes &&
                       (in_issue_warp_num == WW'(w));
    assign clr_valid = in_writeback_valid &&
                       (in_writeback_warp_num == WW'(w));
    assign flush     = in_flush_valid && (in_flush_warp_num == WW'(w));

    vx_scoreboard_warp #(
      .NR (NR),
      .RW (RW)
    ) u_warp (
      .clk          (clk),
      .reset        (reset),
      .set_valid    (set_valid),
      .set_reg      (in_issue_rd),
      .clr_valid    (clr_valid),
      .clr_reg      (in_writeback_dest),
      .flush        (flush),
      .tap_src1     (in_issue_src1),
      .tap_src2     (in_issue_src2),
      .tap_rd       (in_issue_rd),
      .tap_hit1     (hit1_w[w]),
      .tap_hit2     (hit2_w[w]),
      .tap_hitd     (hitd_w[w]),
      .busy         (out_warp_busy[w]),
      .pending_next (next_w[w])
    );
  end

`ifdef SCB_WB_BYPASS_EN
  logic wb_same_warp;
  assign wb_same_warp = in_writeback_valid &&
                        (in_writeback_warp_num == in_issue_warp_num);

  // A register being retired this very cycle no longer blocks decode.
  // The warp module still resolves set-vs-clear on that bit in favour of
  // the set, so a WAW issue in the writeback cycle stays pending.
  always_comb begin
    hit1 = hit1_w[in_issue_warp_num] &&
           !(wb_same_warp && (in_writeback_dest == in_issue_src1));
    hit2 = hit2_w[in_issue_warp_num] &&
           !(wb_same_warp && (in_writeback_dest == in_issue_src2));
    hitd = hitd_w[in_issue_warp_num] &&
           !(wb_same_warp && (in_writeback_dest == in_issue_rd));
  end
`else
  // Without the bypass the hazard check sees registered state only.
  always_comb begin
    hit1 = hit1_w[in_issue_warp_num];
    hit2 = hit2_w[in_issue_warp_num];
    hitd = hitd_w[in_issue_warp_num];
  end
`endif

  // Stall on RAW against either source, or WAW against the destination
  // when the instruction actually writes back. Fire is simply the
  // complement qualified by valid.
  always_comb begin
    out_issue_stall = NO_STALL;
    if (in_issue_valid && (hit1 || hit2 || (issue_writes && hitd))) begin
      out_issue_stall = STALL;
    end
    out_issue_fire = in_issue_valid && !out_issue_stall;
  end

  // Popcount of the whole next-state table. Registering it gives a count
  // that always matches the current table contents.
  always_comb begin
    count_next = '0;
    for (int w = 0; w < NW; w++) begin
      for (int r = 0; r < NR; r++) begin
        count_next = count_next + CW'(next_w[w][r]);
      end
    end
  end

  // Count register; the width holds NW*(NR-1) so it can never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_pending_count <= '0;
    end else begin
      out_pending_count <= count_next;
    end
  end

endmodule
